// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared state encodings, requester indices and helpers for the memory arbiter
package mcu_pkg;

   localparam logic [0:0] ARB    = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   localparam int REQ_FETCH = 0;
   localparam int REQ_LSU   = 1;
   localparam int REQ_DMA   = 2;

   // Next index with wraparound from n-1 back to 0.
   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/mcu_mem_arb_if.sv
// rtl/mcu_mem_arb_if.sv - requester and SRAM bus bundle for the memory arbiter
interface mcu_mem_arb_if #(
   parameter int NREQ   = 3,
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic [NREQ-1:0]            req;
   logic [NREQ-1:0]            lock;
   logic [NREQ-1:0]            we;
   logic [NREQ*ADDR_W-1:0]     addr;
   logic [NREQ*DATA_W-1:0]     wdata;
   logic [NREQ*DATA_W/8-1:0]   wstrb;
   logic [NREQ-1:0]            gnt;
   logic [NREQ-1:0]            rvalid;
   logic [DATA_W-1:0]          rdata;
   logic                       mem_en;
   logic                       mem_we;
   logic [ADDR_W-1:0]          mem_addr;
   logic [DATA_W-1:0]          mem_wdata;
   logic [DATA_W/8-1:0]        mem_wstrb;
   logic [DATA_W-1:0]          mem_rdata;

   // Requesters plus the SRAM model sit on the master side.
   modport master (
      output req, lock, we, addr, wdata, wstrb, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
   );

   modport slave (
      input  req, lock, we, addr, wdata, wstrb, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
   );
endinterface

// File: rtl/mcu_rr_pick.sv
// rtl/mcu_rr_pick.sv - combinational round-robin search upward from rr_ptr with wraparound
module mcu_rr_pick #(
   parameter int NREQ  = 3,
   parameter int IDX_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic             any,
   output logic [IDX_W-1:0] winner
);

   int idx;

   always_comb begin
      any    = 1'b0;
      winner = '0;
      idx    = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(rr_ptr) + i) % NREQ;
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/mcu_mem_arb.sv
// rtl/mcu_mem_arb.sv - single-port SRAM arbiter with round-robin fairness and capped locked bursts
module mcu_mem_arb
   import mcu_pkg::*;
#(
   parameter int NREQ      = 3,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic         clk,
   input  logic         rst,
   mcu_mem_arb_if.slave bus
);

   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNT_W  = $clog2(MAX_BURST + 1);
   localparam int STRB_W = DATA_W / 8;

   logic [0:0]       state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner;
   logic [CNT_W-1:0] burst_cnt;
   logic [NREQ-1:0]  rd_pend;

   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;
   logic             gnt_any;
   logic [IDX_W-1:0] gnt_idx;
   logic [NREQ-1:0]  lock_q;
   logic [NREQ-1:0]  rd_next;
   logic             burst_more;

   assign lock_q = bus.lock & bus.req;

   mcu_rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr),
      .any    (pick_any),
      .winner (pick_idx)
   );

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = pick_idx;
      if (!rst) begin
         if (state == ARB) begin
            gnt_any = pick_any;
         end else begin
            gnt_any = bus.req[owner];
            gnt_idx = owner;
         end
      end
   end

   always_comb begin
      bus.gnt       = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.mem_wstrb = '0;
      if (gnt_any) begin
         bus.gnt[gnt_idx] = 1'b1;
         bus.mem_en       = 1'b1;
         bus.mem_we       = bus.we[gnt_idx];
         bus.mem_addr     = bus.addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
         bus.mem_wdata    = bus.wdata[int'(gnt_idx)*DATA_W +: DATA_W];
         bus.mem_wstrb    = bus.wstrb[int'(gnt_idx)*STRB_W +: STRB_W];
      end
   end

   assign rd_next = (gnt_any && !bus.we[gnt_idx]) ? (NREQ'(1) << gnt_idx) : '0;

   // Gating with rst drops a read that was granted the cycle before reset.
   assign bus.rvalid = rst ? '0 : rd_pend;
   assign bus.rdata  = (!rst && (|rd_pend)) ? bus.mem_rdata : '0;

   // Stay locked only while the owner keeps granting with lock held and the cap is not reached.
   assign burst_more = gnt_any && lock_q[owner] && ((int'(burst_cnt) + 1) < MAX_BURST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB;
         rr_ptr    <= '0;
         owner     <= '0;
         burst_cnt <= '0;
         rd_pend   <= '0;
      end else begin
         rd_pend <= rd_next;
         if (state == ARB) begin
            if (pick_any) begin
               rr_ptr <= IDX_W'(wrap_inc(int'(pick_idx), NREQ));
               if (lock_q[pick_idx] && MAX_BURST > 1) begin
                  state     <= LOCKED;
                  owner     <= pick_idx;
                  burst_cnt <= CNT_W'(1);
               end
            end
         end else begin
            if (burst_more) begin
               burst_cnt <= burst_cnt + 1'b1;
            end else begin
               state     <= ARB;
               rr_ptr    <= IDX_W'(wrap_inc(int'(owner), NREQ));
               burst_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mcu_mem_arb.sv
// tb/tb_mcu_mem_arb.sv - directed self-checking bench for mcu_mem_arb
module tb_mcu_mem_arb;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mcu_mem_arb_if #(.NREQ(3), .ADDR_W(12), .DATA_W(32)) bus ();

   mcu_mem_arb #(
      .NREQ      (3),
      .ADDR_W    (12),
      .DATA_W    (32),
      .MAX_BURST (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: unwritten words read back as 0xC0000000 | address.
   logic [31:0] mem    [4096];
   bit          mem_ok [4096];

   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.mem_wstrb[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
            mem_ok[bus.mem_addr] <= 1'b1;
         end else begin
            bus.mem_rdata <= mem_ok[bus.mem_addr] ? mem[bus.mem_addr]
                                                  : (32'hC000_0000 | 32'(bus.mem_addr));
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int i, input logic [11:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      bus.addr[i*12 +: 12]  = a;
      bus.wdata[i*32 +: 32] = d;
      bus.wstrb[i*4 +: 4]   = s;
   endtask

   logic [2:0]  rr_gnt   [6]  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [31:0] rr_rdata [6]  = '{32'hC000_0001, 32'hC000_0002, 32'hC000_0003,
                                  32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
   logic [2:0]  bc_gnt   [10] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                  3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
   logic [2:0]  er_req   [5]  = '{3'b111, 3'b111, 3'b111, 3'b110, 3'b110};
   logic [2:0]  er_lock  [5]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
   logic [2:0]  er_gnt   [5]  = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b010};

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      bus.req  = 3'b111;
      bus.lock = 3'b000;
      bus.we   = 3'b000;
      bus.addr = '0;
      bus.wdata = '0;
      bus.wstrb = '0;
      set_port(0, 12'h001, 32'h0, 4'h0);
      set_port(1, 12'h002, 32'h0, 4'h0);
      set_port(2, 12'h003, 32'h0, 4'h0);

      // reset holds everything quiet even with all requests high
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst_gnt", 64'(bus.gnt), 64'h0);
      chk("rst_mem_en", 64'(bus.mem_en), 64'h0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
      chk("rst_rdata", 64'(bus.rdata), 64'h0);

      // round robin with all three requesting reads
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk($sformatf("rr_gnt%0d", k), 64'(bus.gnt), 64'(rr_gnt[k]));
         if (k > 0) begin
            chk($sformatf("rr_rvalid%0d", k), 64'(bus.rvalid), 64'(rr_gnt[k-1]));
            chk($sformatf("rr_rdata%0d", k), 64'(bus.rdata), 64'(rr_rdata[k-1]));
         end
         next_cycle();
      end
      bus.req = 3'b000;
      @(negedge clk);
      chk("idle_gnt", 64'(bus.gnt), 64'h0);
      chk("idle_mem_en", 64'(bus.mem_en), 64'h0);
      chk("idle_mem_addr", 64'(bus.mem_addr), 64'h0);
      chk("rr_last_rvalid", 64'(bus.rvalid), 64'h4);
      chk("rr_last_rdata", 64'(bus.rdata), 64'hC000_0003);
      next_cycle();
      @(negedge clk);
      chk("idle_rvalid", 64'(bus.rvalid), 64'h0);
      chk("idle_rdata", 64'(bus.rdata), 64'h0);

      // LSU write then read back
      set_port(1, 12'h010, 32'hDEAD_BEEF, 4'hF);
      bus.req = 3'b010;
      bus.we  = 3'b010;
      @(negedge clk);
      chk("wr_gnt", 64'(bus.gnt), 64'h2);
      chk("wr_mem_we", 64'(bus.mem_we), 64'h1);
      chk("wr_mem_addr", 64'(bus.mem_addr), 64'h010);
      chk("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
      chk("wr_mem_wstrb", 64'(bus.mem_wstrb), 64'hF);
      next_cycle();
      bus.we = 3'b000;
      @(negedge clk);
      chk("rd_gnt", 64'(bus.gnt), 64'h2);
      chk("rd_mem_we", 64'(bus.mem_we), 64'h0);
      chk("wr_no_rvalid", 64'(bus.rvalid), 64'h0);
      next_cycle();
      bus.req = 3'b000;
      @(negedge clk);
      chk("rd_rvalid", 64'(bus.rvalid), 64'h2);
      chk("rd_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);

      // burst cap: DMA locked, fetch waiting (rr_ptr is 2 here)
      next_cycle();
      set_port(2, 12'h020, 32'h0, 4'h0);
      bus.req  = 3'b101;
      bus.lock = 3'b100;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("bc_gnt%0d", k), 64'(bus.gnt), 64'(bc_gnt[k]));
         next_cycle();
      end
      bus.req  = 3'b000;
      bus.lock = 3'b000;
      next_cycle();

      // early release: fetch owns three beats then drops req and lock
      for (int k = 0; k < 5; k++) begin
         bus.req  = er_req[k];
         bus.lock = er_lock[k];
         @(negedge clk);
         chk($sformatf("er_gnt%0d", k), 64'(bus.gnt), 64'(er_gnt[k]));
         next_cycle();
      end
      bus.req  = 3'b000;
      bus.lock = 3'b000;
      next_cycle();

      // reset right after a locked fetch read is granted
      bus.req  = 3'b001;
      bus.lock = 3'b001;
      @(negedge clk);
      chk("pre_rst_gnt", 64'(bus.gnt), 64'h1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rvalid", 64'(bus.rvalid), 64'h0);
      chk("mid_rst_rdata", 64'(bus.rdata), 64'h0);
      chk("mid_rst_gnt", 64'(bus.gnt), 64'h0);
      chk("mid_rst_mem_en", 64'(bus.mem_en), 64'h0);
      next_cycle();
      rst      = 1'b0;
      bus.req  = 3'b111;
      bus.lock = 3'b000;
      @(negedge clk);
      chk("post_rst_rvalid", 64'(bus.rvalid), 64'h0);
      chk("post_rst_gnt", 64'(bus.gnt), 64'h1);
      next_cycle();
      bus.req = 3'b110;
      @(negedge clk);
      chk("post_rst_gnt2", 64'(bus.gnt), 64'h2);
      chk("post_rst_rvalid2", 64'(bus.rvalid), 64'h1);
      chk("post_rst_rdata2", 64'(bus.rdata), 64'hC000_0001);
      next_cycle();
      bus.req = 3'b000;
      next_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mcu_mem_arb.md
MCU_MEM_ARB -- requirements
Module: mcu_mem_arb

Interface
REQ-001 Parameter NREQ, default 3: number of requesters. Index 0 is CPU fetch, 1 is CPU load/store, 2 is DMA.
REQ-002 Parameter ADDR_W, default 12: word-address width.
REQ-003 Parameter DATA_W, default 32: data width. Byte strobes are DATA_W/8 bits wide.
REQ-004 Parameter MAX_BURST, default 8: maximum consecutive locked grants to one requester.
REQ-005 clk  in  1: the single clock. All state updates on the rising edge.
REQ-006 rst  in  1: synchronous, active-high reset.
REQ-007 req  in  NREQ: per-requester access request.
REQ-008 lock  in  NREQ: per-requester burst-lock request. Qualified by req.
REQ-009 we  in  NREQ: per-requester write enable.
REQ-010 addr  in  NREQ*ADDR_W: flattened addresses. Requester i occupies slice [i*ADDR_W +: ADDR_W].
REQ-011 wdata  in  NREQ*DATA_W: flattened write data.
REQ-012 wstrb  in  NREQ*DATA_W/8: flattened byte strobes.
REQ-013 gnt  out  NREQ: one-hot access accepted this cycle.
REQ-014 rvalid  out  NREQ: one-hot read data valid.
REQ-015 rdata  out  DATA_W: read data, shared by all requesters.
REQ-016 mem_en, mem_we  out  1 each: SRAM enable and write.
REQ-017 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_wstrb  out  DATA_W/8: SRAM command fields.
REQ-018 mem_rdata  in  DATA_W: SRAM read data, valid one cycle after a read enable.

Function
REQ-019 Each cycle, the arbiter accepts at most one access. gnt, mem_en and the mem_* command fields are combinational from the current req and the current state.
REQ-020 A requester shall hold req and its command fields stable until it sees gnt. The access completes in the cycle gnt is high.
REQ-021 In state ARB, the winner is the first requesting index found searching upward from rr_ptr, wrapping from NREQ-1 to 0.
REQ-022 On any grant in ARB, rr_ptr loads winner+1 modulo NREQ. rr_ptr is unchanged when there is no grant.
REQ-023 If the ARB winner also asserts lock, state moves to LOCKED: owner is the winner, burst_cnt is 1.
REQ-024 In LOCKED, only the owner can be granted. Other requests wait without gnt.
REQ-025 In LOCKED, each owner grant increments burst_cnt.
REQ-026 LOCKED returns to ARB in any of three cases: the owner's lock is low in a cycle without an owner grant; the owner is granted with lock low; or a grant makes burst_cnt reach MAX_BURST.
REQ-027 On return to ARB, rr_ptr is owner+1 modulo NREQ. This prevents starvation of the other requesters.
REQ-028 A granted read (we low) asserts the matching rvalid bit exactly one cycle later. rdata equals mem_rdata in that cycle.
REQ-029 A granted write produces no rvalid.
REQ-030 Back-to-back reads from different requesters each get their own one-cycle rvalid. No bubble is inserted.
REQ-031 When no access is granted, mem_en and mem_we are 0. mem_addr, mem_wdata and mem_wstrb are 0.
REQ-032 rdata is 0 in any cycle where rvalid is all zero.

Reset
REQ-033 While rst is high: state is ARB, rr_ptr is 0, burst_cnt is 0, the owner is 0, and the pending-read register is cleared.
REQ-034 While rst is high, gnt, mem_en and mem_we are 0.
REQ-035 In the cycle after rst is sampled high, rvalid is 0 and rdata is 0. A read granted just before reset is dropped.
REQ-036 Reset asserted during LOCKED abandons the burst. No partial rvalid follows.

Structure
REQ-037 The shared package mcu_pkg holds the state encodings ARB=1'b0 and LOCKED=1'b1, and the requester index constants REQ_FETCH, REQ_LSU and REQ_DMA.
REQ-038 The round-robin search is a sub-module, mcu_rr_pick. It is combinational, takes (req mask, rr_ptr) and returns (any, winner index).
REQ-039 All other logic stays in mcu_mem_arb.

Verification
REQ-040 Reset behaviour. Stimulus: req=3'b111 while rst is high. Response: gnt=0 and mem_en=0. In the first cycle after reset, gnt=3'b001 because rr_ptr=0.
REQ-041 Round-robin fairness. Stimulus: req=3'b111 held, no lock, for 6 cycles. Response: gnt sequence 001, 010, 100, 001, 010, 100. rvalid follows each read by one cycle.
REQ-042 Burst cap. Stimulus: DMA holds req=1 and lock=1 for 10 cycles, and fetch requests throughout. Response: DMA gets 8 consecutive grants, then fetch is granted in cycle 9.
REQ-043 Write then read. Stimulus: LSU writes 0xDEADBEEF, wstrb=4'hF, to addr 0x010, then reads 0x010. Response: mem_we=1 on the write and no rvalid for it. The read gives rvalid=3'b010 and rdata=0xDEADBEEF.
REQ-044 Reset mid-operation. Stimulus: fetch read granted at cycle N, rst high at cycle N+1. Response: rvalid=0 at N+1, and the FSM is in ARB with rr_ptr=0 afterwards.
REQ-045 Early lock release. Stimulus: owner drops lock after 3 beats while LSU is requesting. Response: the next grant goes to the requester after the owner.
